// File: rtl/fft_peak_finder.sv
// fft_peak_finder: scans a bin range of an FFT result RAM and reports the bin with the largest |re|+|im|
module fft_peak_finder #(
    parameter int FIRST_BIN = 1,
    parameter int LAST_BIN  = 127
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        RdEn,
    output logic [7:0]  RdAddr,
    input  logic [31:0] RdRe,
    input  logic [31:0] RdIm,
    output logic [7:0]  PeakBin,
    output logic [31:0] PeakMag,
    output logic        Busy,
    output logic        Done
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;
    localparam logic [7:0] FIRST = 8'(FIRST_BIN);
    localparam logic [7:0] LAST  = 8'(LAST_BIN);
    state_t      r_state, w_next;
    logic        r_vld, r_first, w_take, w_accept;
    logic [7:0]  r_eval_bin, r_max_bin, w_best_bin;
    logic [31:0] r_max, w_mag, w_best_mag;
    logic [32:0] w_abs_re, w_abs_im, w_sum;
    assign w_accept = (r_state == IDLE) && Start;
    // next state and per-state strobes; any illegal encoding falls back to IDLE
    always_comb begin
        w_next = IDLE;
        RdEn   = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            IDLE:    w_next = Start ? READ : IDLE;
            READ: begin
                RdEn   = 1'b1;
                Busy   = 1'b1;
                w_next = (RdAddr == LAST) ? DRAIN : READ;
            end
            DRAIN: begin
                Busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                Busy   = 1'b1;
                Done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // magnitude of the returning sample, 33-bit so abs(-2^31) is exact, then saturated to 32 bits
    always_comb begin
        w_abs_re   = RdRe[31] ? 33'd0 - {RdRe[31], RdRe} : {1'b0, RdRe};
        w_abs_im   = RdIm[31] ? 33'd0 - {RdIm[31], RdIm} : {1'b0, RdIm};
        w_sum      = w_abs_re + w_abs_im;
        w_mag      = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
        w_take     = r_first || (w_mag > r_max);
        w_best_mag = w_take ? w_mag : r_max;
        w_best_bin = w_take ? r_eval_bin : r_max_bin;
    end
    // state register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // read address: loaded on accept, walks up to LAST_BIN and holds there
    always_ff @(posedge Clk) begin
        if (Reset)                                 RdAddr <= 8'd0;
        else if (w_accept)                         RdAddr <= FIRST;
        else if (r_state == READ && RdAddr != LAST) RdAddr <= RdAddr + 8'd1;
    end
    // one-stage pipeline matching the RAM read latency
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld      <= 1'b0;
            r_eval_bin <= 8'd0;
        end else begin
            r_vld      <= RdEn;
            r_eval_bin <= RdAddr;
        end
    end
    // running maximum; the first evaluated bin of a search always loads it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_first   <= 1'b0;
            r_max     <= 32'd0;
            r_max_bin <= 8'd0;
        end else if (w_accept) begin
            r_first <= 1'b1;
        end else if (r_vld) begin
            r_first   <= 1'b0;
            r_max     <= w_best_mag;
            r_max_bin <= w_best_bin;
        end
    end
    // published result, including the last bin evaluated during DRAIN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PeakBin <= 8'd0;
            PeakMag <= 32'd0;
        end else if (r_state == DRAIN) begin
            PeakBin <= w_best_bin;
            PeakMag <= w_best_mag;
        end
    end
endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed and random peak searches checked against an array-based reference model
module tb_fft_peak_finder;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Start1 = 1'b0;
    logic        RdEn, RdEn1, Busy, Busy1, Done, Done1;
    logic [7:0]  RdAddr, RdAddr1, PeakBin, PeakBin1;
    logic [31:0] RdRe, RdIm, RdRe1, RdIm1, PeakMag, PeakMag1;
    logic signed [31:0] ram_re [256];
    logic signed [31:0] ram_im [256];
    int n_pass = 0;
    int n_total = 0;
    int rd1_cnt = 0;

    always #5 Clk = ~Clk;

    fft_peak_finder dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .RdEn(RdEn), .RdAddr(RdAddr),
        .RdRe(RdRe), .RdIm(RdIm), .PeakBin(PeakBin), .PeakMag(PeakMag),
        .Busy(Busy), .Done(Done)
    );

    fft_peak_finder #(.FIRST_BIN(7), .LAST_BIN(7)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start1), .RdEn(RdEn1), .RdAddr(RdAddr1),
        .RdRe(RdRe1), .RdIm(RdIm1), .PeakBin(PeakBin1), .PeakMag(PeakMag1),
        .Busy(Busy1), .Done(Done1)
    );

    // result RAM: data appears the cycle after the read strobe
    always @(posedge Clk) begin
        if (RdEn) begin
            RdRe <= ram_re[RdAddr];
            RdIm <= ram_im[RdAddr];
        end
        if (RdEn1) begin
            RdRe1   <= ram_re[RdAddr1];
            RdIm1   <= ram_im[RdAddr1];
            rd1_cnt <= rd1_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mag_of(input int b);
        longint a, c, s;
        a = longint'(ram_re[b]);
        c = longint'(ram_im[b]);
        s = (a < 0 ? -a : a) + (c < 0 ? -c : c);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task automatic model(input int first, input int last, output logic [31:0] bin, output logic [31:0] mag);
        bin = 32'(first);
        mag = mag_of(first);
        for (int i = first + 1; i <= last; i++)
            if (mag_of(i) > mag) begin
                bin = 32'(i);
                mag = mag_of(i);
            end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) begin
            ram_re[i] = 0;
            ram_im[i] = 0;
        end
    endtask

    task automatic do_search(input string tag);
        logic [31:0] eb, em;
        int n;
        model(1, 127, eb, em);
        @(negedge Clk) Start = 1'b1;
        @(posedge Clk) #1 Start = 1'b0;
        n = 0;
        do begin
            @(negedge Clk) n++;
        end while (!Done && n < 300);
        check({tag, "_latency"}, 32'(n), 32'd129);
        check({tag, "_bin"}, 32'(PeakBin), eb);
        check({tag, "_mag"}, PeakMag, em);
        check({tag, "_busy_in_done"}, 32'(Busy), 32'd1);
    endtask

    initial begin
        int n, lows, done_seen;
        logic [31:0] eb, em;
        clear_ram();
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_rden", 32'(RdEn), 0);
        check("rst_addr", 32'(RdAddr), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_bin", 32'(PeakBin), 0);
        check("rst_mag", PeakMag, 0);

        ram_re[40] = 1000;
        ram_im[40] = -500;
        do_search("tone40");
        check("tone40_bin_lit", 32'(PeakBin), 32'd40);
        check("tone40_mag_lit", PeakMag, 32'd1500);

        clear_ram();
        ram_re[10] = 700;
        ram_re[90] = -300;
        ram_im[90] = 400;
        do_search("tie");
        check("tie_bin_lit", 32'(PeakBin), 32'd10);

        clear_ram();
        ram_re[5] = 32'sh8000_0000;
        ram_im[5] = 32'sh8000_0000;
        do_search("sat");
        check("sat_mag_lit", PeakMag, 32'hFFFF_FFFF);
        check("sat_bin_lit", 32'(PeakBin), 32'd5);

        clear_ram();
        ram_re[0] = 32'sh7FFF_0000;
        ram_im[128] = -32'sh4000_0000;
        do_search("range");
        check("range_bin_lit", 32'(PeakBin), 32'd1);
        check("range_mag_lit", PeakMag, 32'd0);

        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 256; i++) begin
                ram_re[i] = (it % 2 == 0) ? $urandom : int'($urandom_range(16)) - 8;
                ram_im[i] = (it % 2 == 0) ? $urandom : int'($urandom_range(16)) - 8;
            end
            do_search($sformatf("rand%0d", it));
        end

        @(negedge Clk) Start = 1'b1;
        @(posedge Clk) #1 Start = 1'b0;
        n = 0;
        do begin
            @(negedge Clk) n++;
        end while (n < 60);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_rden", 32'(RdEn), 0);
        check("midrst_addr", 32'(RdAddr), 0);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_done", 32'(Done), 0);
        check("midrst_bin", 32'(PeakBin), 0);
        check("midrst_mag", PeakMag, 0);
        done_seen = 0;
        repeat (150) @(negedge Clk) if (Done) done_seen++;
        check("midrst_no_done", 32'(done_seen), 0);
        do_search("after_rst");

        @(negedge Clk) Start = 1'b1;
        n = 0;
        do begin
            @(negedge Clk) n++;
        end while (!Done && n < 300);
        check("b2b_first_done", 32'(Done), 1);
        for (int s = 0; s < 2; s++) begin
            n = 0;
            lows = 0;
            do begin
                @(negedge Clk) n++;
                if (!Busy) lows++;
                if (n == 1) check($sformatf("b2b%0d_idle", s), {30'd0, Busy, RdEn}, 32'd0);
                if (n == 2) check($sformatf("b2b%0d_read", s), {30'd0, Busy, RdEn}, 32'd3);
            end while (!Done && n < 300);
            if (s == 1) Start = 1'b0;
            check($sformatf("b2b%0d_period", s), 32'(n), 32'd130);
            check($sformatf("b2b%0d_idle_cycles", s), 32'(lows), 32'd1);
        end
        @(negedge Clk);
        @(negedge Clk);
        check("b2b_stops", 32'(Busy), 0);

        ram_re[7] = -123456;
        ram_im[7] = 654321;
        model(7, 7, eb, em);
        @(negedge Clk) Start1 = 1'b1;
        @(posedge Clk) #1 Start1 = 1'b0;
        n = 0;
        do begin
            @(negedge Clk) n++;
        end while (!Done1 && n < 50);
        check("single_latency", 32'(n), 32'd3);
        check("single_reads", 32'(rd1_cnt), 32'd1);
        check("single_bin", 32'(PeakBin1), eb);
        check("single_mag", PeakMag1, em);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft_peak_finder.md
FFT_PEAK_FINDER -- requirements
Module: fft_peak_finder

Interface
REQ-001 The block SHALL have parameter FIRST_BIN, default 1, first bin index searched (inclusive).
REQ-002 The block SHALL have parameter LAST_BIN, default 127, last bin index searched (inclusive); FIRST_BIN <= LAST_BIN <= 255.
REQ-003 The block SHALL have port Clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Start  input  1  request a peak search; sampled only in IDLE.
REQ-006 The block SHALL have port RdEn  output  1  read strobe to the FFT result RAM read port.
REQ-007 The block SHALL have port RdAddr  output  8  bin address to the FFT result RAM.
REQ-008 The block SHALL have port RdRe  input  32  signed real part, valid the cycle after RdEn/RdAddr.
REQ-009 The block SHALL have port RdIm  input  32  signed imaginary part, same timing as RdRe.
REQ-010 The block SHALL have port PeakBin  output  8  index of the largest-magnitude bin from the last completed search.
REQ-011 The block SHALL have port PeakMag  output  32  unsigned magnitude of PeakBin.
REQ-012 The block SHALL have port Busy  output  1  high from the cycle after Start is accepted through the DONE cycle.
REQ-013 The block SHALL have port Done  output  1  one-cycle pulse marking a completed search.

Function
REQ-014 The state machine SHALL have the states IDLE, READ, DRAIN and DONE, one-hot encoded, with any illegal encoding returning to IDLE on the next edge.
REQ-015 In IDLE with Start=1, the next state SHALL be READ and RdAddr SHALL be loaded with FIRST_BIN; with Start=0 the block stays in IDLE.
REQ-016 In READ, RdEn SHALL be 1 and RdAddr SHALL increment by 1 per cycle; after the cycle with RdAddr=LAST_BIN the next state is DRAIN.
REQ-017 In DRAIN, RdEn SHALL be 0 and the read data for LAST_BIN SHALL be evaluated; the next state is DONE.
REQ-018 In DONE, Done SHALL be 1 for exactly one cycle and the next state is IDLE.
REQ-019 Magnitude SHALL be |RdRe| + |RdIm|, computed at 33 bits, with abs(-2^31) = 2^31; a sum above 32'hFFFFFFFF SHALL saturate to 32'hFFFFFFFF.
REQ-020 Evaluation SHALL be pipelined one stage behind the address, using a valid flag delayed one cycle from RdEn, so data is evaluated only on cycles when the flag is 1.
REQ-021 The first evaluated bin of a search SHALL load the running maximum unconditionally; each later bin replaces it only if its magnitude is strictly greater.
- Ties: the lowest index wins.
REQ-022 PeakBin and PeakMag SHALL update only at the end of DRAIN, remain stable during DONE, and hold until the next search completes.
REQ-023 Latency: with Start sampled at edge 0, the block SHALL be in READ for cycles 1..N (N = LAST_BIN-FIRST_BIN+1), DRAIN at N+1, and assert Done at cycle N+2.
- Defaults: Done at cycle 129.
REQ-024 Start SHALL be ignored in READ, DRAIN and DONE; a Start in the DONE cycle SHALL NOT begin a new search.
REQ-025 With FIRST_BIN = LAST_BIN, the block SHALL issue exactly one read and report that bin.

Reset
REQ-026 On Reset=1 at a clock edge, the block SHALL enter IDLE with RdEn=0, RdAddr=0, Busy=0, Done=0, PeakBin=0 and PeakMag=0, regardless of the current state.
REQ-027 Reset asserted mid-search SHALL discard all partial results, and no Done pulse SHALL follow.
REQ-028 Reset SHALL take priority over Start in the same cycle.

Verification
REQ-029 The bench SHALL cover: RAM holding a single tone at bin 40 (re=1000, im=-500), all other bins 0, Start pulse -> Done at cycle 129, PeakBin=40, PeakMag=1500.
REQ-030 The bench SHALL cover: bins 10 and 90 both with magnitude 700 -> PeakBin=10 (tie, lowest index wins).
REQ-031 The bench SHALL cover: bin 5 with re=-2^31, im=-2^31 -> PeakMag=32'hFFFFFFFF (saturation), PeakBin=5.
REQ-032 The bench SHALL cover: bins 0 and 128 set to large values with all searched bins 0 -> PeakBin=1, PeakMag=0 (range limits respected).
REQ-033 The bench SHALL cover: Reset at cycle 60 of a search -> all outputs 0 next cycle, no Done; a fresh Start then gives a correct result at 129 cycles.
REQ-034 The bench SHALL cover: Start held high continuously -> searches back-to-back with one IDLE cycle between each Done and the next READ, and Busy low only in those IDLE cycles.
